// File: rtl/arbiter_request_tracker.sv
`timescale 1ns/1ps
// arbiter_request_tracker
//   Per-client outstanding-request counters feeding a round-robin/priority
//   arbiter. Drives the request vector, the packed effective-priority vector
//   and sticky overflow flags. One queued request is retired per accepted grant.
//   Optional aging (define ARB_REQ_AGING_EN) lowers the priority field of
//   long-waiting clients so priority mode cannot starve them.
//   The effective-priority output is named prio because 'priority' is a
//   reserved word in SystemVerilog.
module arbiter_request_tracker #(
  parameter int NUMUNITS     = 9,
  parameter int ADDRESSWIDTH = 3,
  parameter int CNTWIDTH     = 2,
  parameter int AGE_INTERVAL = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUMUNITS-1:0]              req_in,
  input  logic [NUMUNITS*ADDRESSWIDTH-1:0] base_prio,
  input  logic [NUMUNITS-1:0]              grant,
  input  logic                             clear_overflow,
  output logic [NUMUNITS-1:0]              request,
  output logic [NUMUNITS*ADDRESSWIDTH-1:0] prio,
  output logic [NUMUNITS-1:0]              overflow
);

  localparam logic [CNTWIDTH-1:0] CNT_ZERO = {CNTWIDTH{1'b0}};
  localparam logic [CNTWIDTH-1:0] CNT_MAX  = {CNTWIDTH{1'b1}};
  localparam logic [NUMUNITS*ADDRESSWIDTH-1:0] PRIO_LOWEST = {(NUMUNITS*ADDRESSWIDTH){1'b1}};

  logic [CNTWIDTH-1:0]              cnt_r     [NUMUNITS];
  logic [CNTWIDTH-1:0]              cnt_nxt_s [NUMUNITS];
  logic [NUMUNITS-1:0]              accept_s;
  logic [NUMUNITS-1:0]              drop_s;
  logic [NUMUNITS-1:0]              req_nxt_s;
  logic [NUMUNITS-1:0]              ovf_nxt_s;
  logic [NUMUNITS*ADDRESSWIDTH-1:0] prio_nxt_s;

  // A grant only retires a request when the client actually has one queued.
  always_comb begin
    for (int i = 0; i < NUMUNITS; i++) begin
      accept_s[i] = grant[i] && (cnt_r[i] != CNT_ZERO);
    end
  end

  // Next counter value per client; a pulse arriving on a full counter is dropped.
  always_comb begin
    for (int i = 0; i < NUMUNITS; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      drop_s[i]    = 1'b0;
      case ({req_in[i], accept_s[i]})
        2'b10: begin
          if (cnt_r[i] == CNT_MAX) begin
            drop_s[i] = 1'b1;
          end else begin
            cnt_nxt_s[i] = cnt_r[i] + CNTWIDTH'(1);
          end
        end
        2'b01:   cnt_nxt_s[i] = cnt_r[i] - CNTWIDTH'(1);
        default: cnt_nxt_s[i] = cnt_r[i];
      endcase
      req_nxt_s[i] = (cnt_nxt_s[i] != CNT_ZERO);
    end
  end

  // Sticky overflow: clear wipes all flags, but a drop in the same cycle still sets its bit.
  always_comb begin
    if (clear_overflow) begin
      ovf_nxt_s = drop_s;
    end else begin
      ovf_nxt_s = overflow | drop_s;
    end
  end

  // Counter, request and overflow registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUMUNITS; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      request  <= {NUMUNITS{1'b0}};
      overflow <= {NUMUNITS{1'b0}};
    end else begin
      for (int i = 0; i < NUMUNITS; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      request  <= req_nxt_s;
      overflow <= ovf_nxt_s;
    end
  end

`ifdef ARB_REQ_AGING_EN
  localparam int PW = (AGE_INTERVAL > 1) ? $clog2(AGE_INTERVAL) : 1;
  localparam logic [PW-1:0]           PRE_LAST = PW'(AGE_INTERVAL - 1);
  localparam logic [ADDRESSWIDTH-1:0] AGE_ZERO = {ADDRESSWIDTH{1'b0}};
  localparam logic [ADDRESSWIDTH-1:0] AGE_MAX  = {ADDRESSWIDTH{1'b1}};

  logic [PW-1:0]           pre_r;
  logic                    tick_s;
  logic [ADDRESSWIDTH-1:0] age_r     [NUMUNITS];
  logic [ADDRESSWIDTH-1:0] age_nxt_s [NUMUNITS];

  // base - age evaluated one bit wider so a negative result clamps to 0 (highest).
  function automatic logic [ADDRESSWIDTH-1:0] sub_clamp(input logic [ADDRESSWIDTH-1:0] base,
                                                        input logic [ADDRESSWIDTH-1:0] age);
    logic [ADDRESSWIDTH:0] diff;
    diff = {1'b0, base} - {1'b0, age};
    if (diff[ADDRESSWIDTH]) begin
      return AGE_ZERO;
    end else begin
      return diff[ADDRESSWIDTH-1:0];
    end
  endfunction

  assign tick_s = (pre_r == PRE_LAST);

  // Aging prescaler: free-running 0..AGE_INTERVAL-1.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_r <= {PW{1'b0}};
    end else if (tick_s) begin
      pre_r <= {PW{1'b0}};
    end else begin
      pre_r <= pre_r + PW'(1);
    end
  end

  // Age per client: cleared on service or empty queue, saturating increment on tick.
  always_comb begin
    for (int i = 0; i < NUMUNITS; i++) begin
      if (accept_s[i] || (cnt_nxt_s[i] == CNT_ZERO)) begin
        age_nxt_s[i] = AGE_ZERO;
      end else if (tick_s && (cnt_r[i] != CNT_ZERO) && (age_r[i] != AGE_MAX)) begin
        age_nxt_s[i] = age_r[i] + ADDRESSWIDTH'(1);
      end else begin
        age_nxt_s[i] = age_r[i];
      end
    end
  end

  // Age registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUMUNITS; i++) begin
        age_r[i] <= AGE_ZERO;
      end
    end else begin
      for (int i = 0; i < NUMUNITS; i++) begin
        age_r[i] <= age_nxt_s[i];
      end
    end
  end

  // Effective priority: static priority promoted by the registered age.
  always_comb begin
    prio_nxt_s = PRIO_LOWEST;
    for (int i = 0; i < NUMUNITS; i++) begin
      prio_nxt_s[i*ADDRESSWIDTH +: ADDRESSWIDTH] =
        sub_clamp(base_prio[i*ADDRESSWIDTH +: ADDRESSWIDTH], age_r[i]);
    end
  end
`else
  // Effective priority is the static priority, registered.
  always_comb begin
    prio_nxt_s = base_prio;
  end
`endif

  // Priority output register; every field parks at lowest priority in reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      prio <= PRIO_LOWEST;
    end else begin
      prio <= prio_nxt_s;
    end
  end

endmodule

// File: tb/tb_arbiter_request_tracker.sv
`timescale 1ns/1ps
// Self-checking bench for arbiter_request_tracker: queue-level reference model,
// per-cycle comparison of every output, directed scenarios plus random traffic.
module tb_arbiter_request_tracker;

  localparam int NU    = 9;
  localparam int AW    = 3;
  localparam int CW    = 2;
  localparam int AI    = 16;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int PMAX  = (1 << AW) - 1;
  localparam int ALL1  = (1 << (NU*AW)) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [NU-1:0]     req_in;
  logic [NU*AW-1:0]  base_prio;
  logic [NU-1:0]     grant;
  logic              clear_overflow;
  logic [NU-1:0]     request;
  logic [NU*AW-1:0]  prio;
  logic [NU-1:0]     overflow;

  always #5 clock = ~clock;

  arbiter_request_tracker #(
    .NUMUNITS(NU), .ADDRESSWIDTH(AW), .CNTWIDTH(CW), .AGE_INTERVAL(AI)
  ) dut (
    .clock(clock), .reset(reset), .req_in(req_in), .base_prio(base_prio),
    .grant(grant), .clear_overflow(clear_overflow),
    .request(request), .prio(prio), .overflow(overflow)
  );

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // reference model state
  int m_cnt  [NU];
  bit m_ov   [NU];
  int m_age  [NU];
  int m_prio [NU];
  int m_pre;

  function automatic int field(input logic [NU*AW-1:0] v, input int i);
    return int'(v[i*AW +: AW]);
  endfunction

  // Apply one clock edge worth of rules to the model, using the current inputs.
  function automatic void model_update();
    int old_cnt;
    bit acc;
    bit drop;
    bit tk;
    if (reset) begin
      for (int i = 0; i < NU; i++) begin
        m_cnt[i] = 0; m_ov[i] = 1'b0; m_age[i] = 0; m_prio[i] = PMAX;
      end
      m_pre = 0;
    end else begin
      tk    = (m_pre == AI - 1);
      m_pre = (m_pre + 1) % AI;
      for (int i = 0; i < NU; i++) begin
`ifdef ARB_REQ_AGING_EN
        m_prio[i] = (field(base_prio, i) > m_age[i]) ? field(base_prio, i) - m_age[i] : 0;
`else
        m_prio[i] = field(base_prio, i);
`endif
        old_cnt = m_cnt[i];
        acc     = grant[i] && (old_cnt > 0);
        drop    = 1'b0;
        if (req_in[i] && !acc) begin
          if (old_cnt == CMAX) drop = 1'b1;
          else m_cnt[i] = old_cnt + 1;
        end else if (!req_in[i] && acc) begin
          m_cnt[i] = old_cnt - 1;
        end
        if (clear_overflow) m_ov[i] = 1'b0;
        if (drop) m_ov[i] = 1'b1;
        if (acc || m_cnt[i] == 0) m_age[i] = 0;
        else if (tk && old_cnt > 0 && m_age[i] < PMAX) m_age[i] = m_age[i] + 1;
      end
    end
  endfunction

  function automatic logic [NU-1:0] exp_request();
    logic [NU-1:0] v;
    for (int i = 0; i < NU; i++) v[i] = (m_cnt[i] > 0);
    return v;
  endfunction

  function automatic logic [NU-1:0] exp_overflow();
    logic [NU-1:0] v;
    for (int i = 0; i < NU; i++) v[i] = m_ov[i];
    return v;
  endfunction

  function automatic logic [NU*AW-1:0] exp_prio();
    logic [NU*AW-1:0] v;
    v = '1;
    for (int i = 0; i < NU; i++) v[i*AW +: AW] = AW'(m_prio[i]);
    return v;
  endfunction

  // Compare process: every output against the model, mid-cycle.
  initial begin : compare
    forever begin
      @(negedge clock);
      if (check_en) begin
        checks++;
        if (request !== exp_request()) begin
          failures++;
          $display("FAIL request t=%0t act=%b exp=%b", $time, request, exp_request());
        end
        checks++;
        if (overflow !== exp_overflow()) begin
          failures++;
          $display("FAIL overflow t=%0t act=%b exp=%b", $time, overflow, exp_overflow());
        end
        checks++;
        if (prio !== exp_prio()) begin
          failures++;
          $display("FAIL prio t=%0t act=%h exp=%h", $time, prio, exp_prio());
        end
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    req_in = '0; grant = '0; clear_overflow = 1'b0; reset = 1'b0;
  endtask

  initial begin : stimulus
    int seen[$];
    int v;
    int b1;
    int r;
    reset = 1'b1; req_in = '0; grant = '0; clear_overflow = 1'b0;
    base_prio = NU*AW'({$urandom, $urandom});
    step(); step();
    check_en = 1'b1;
    check_lit("reset_request", int'(request), 0);
    check_lit("reset_overflow", int'(overflow), 0);
    check_lit("reset_prio", int'(prio), ALL1);
    idle();

    // 1: request latency and last-grant retire
    req_in[3] = 1'b1; step(); req_in = '0;
    check_lit("t1_req_rise", int'(request[3]), 1);
    step(); step();
    grant[3] = 1'b1; step(); grant = '0;
    check_lit("t1_req_fall", int'(request[3]), 0);

    // 2: saturation and overflow on unit 0
    for (int k = 0; k < 4; k++) begin
      req_in[0] = 1'b1; step();
      if (k == 2) check_lit("t2_no_ovf_yet", int'(overflow[0]), 0);
    end
    req_in = '0;
    check_lit("t2_ovf_set", int'(overflow[0]), 1);
    check_lit("t2_model_cnt", m_cnt[0], 3);
    for (int k = 0; k < 3; k++) begin
      grant[0] = 1'b1; step();
      check_lit("t2_req_after_grant", int'(request[0]), (k < 2) ? 1 : 0);
    end
    grant = '0;
    check_lit("t2_ovf_sticky", int'(overflow[0]), 1);
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    check_lit("t2_ovf_clear", int'(overflow[0]), 0);

    // 3: simultaneous request and grant
    req_in[5] = 1'b1; step();
    grant[5] = 1'b1; step();
    check_lit("t3_req_hold", int'(request[5]), 1);
    check_lit("t3_model_cnt", m_cnt[5], 1);
    req_in = '0; step(); grant = '0;
    check_lit("t3_req_fall", int'(request[5]), 0);

    // 5: ignored grant on empty unit, reset while busy
    grant[7] = 1'b1; step(); grant = '0;
    check_lit("t5_empty_grant_req", int'(request[7]), 0);
    check_lit("t5_empty_grant_ovf", int'(overflow[7]), 0);
    req_in = 9'b0_0101_0110; step(); req_in = '0; step();
    check_lit("t5_pending", int'(request), 86);
    reset = 1'b1; step(); reset = 1'b0;
    check_lit("t5_reset_req", int'(request), 0);
    check_lit("t5_reset_prio", int'(prio), ALL1);

`ifdef ARB_REQ_AGING_EN
    // 4: aging steps priority down to 0 and saturates
    base_prio[2*AW +: AW] = 3'd5;
    req_in[2] = 1'b1; step(); req_in = '0;
    seen.push_back(field(prio, 2));
    for (int k = 0; k < 130; k++) begin
      step();
      v = field(prio, 2);
      if (v != seen[seen.size()-1]) seen.push_back(v);
    end
    check_lit("t4_steps", seen.size(), 6);
    for (int k = 0; k < seen.size() && k < 6; k++) check_lit("t4_step_val", seen[k], 5 - k);
    check_lit("t4_hold0", field(prio, 2), 0);
    grant[2] = 1'b1; step(); grant = '0; step();
    check_lit("t4_restore", field(prio, 2), 5);
    base_prio[2*AW +: AW] = 3'd1;
    req_in[2] = 1'b1; step(); req_in = '0;
    for (int k = 0; k < 40; k++) step();
    check_lit("t4_clamp", field(prio, 2), 0);
    grant[2] = 1'b1; step(); grant = '0; step();
`else
    // 6: no aging, priority tracks base_prio with one cycle latency
    b1 = field(base_prio, 1);
    req_in[1] = 1'b1; step(); req_in = '0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (k % 20 == 0) check_lit("t6_static", field(prio, 1), b1);
    end
    base_prio[1*AW +: AW] = AW'((b1 + 3) % 8);
    check_lit("t6_before", field(prio, 1), b1);
    step();
    check_lit("t6_after", field(prio, 1), (b1 + 3) % 8);
    grant[1] = 1'b1; step(); grant = '0;
`endif

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if ((k / 200) % 2 == 0) req_in = NU'($urandom & $urandom & $urandom);
      else                    req_in = NU'($urandom & $urandom);
      r = $urandom_range(0, 9);
      if (r < 8)       grant = NU'(1) << $urandom_range(0, NU-1);
      else if (r == 8) grant = NU'($urandom);
      else             grant = '0;
      clear_overflow = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) base_prio = NU*AW'({$urandom, $urandom});
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    idle();
    step();
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
